// File: rtl/ecc_result_serializer_if.sv
// Result stream bundle between the ECC top, the serializer and the host bridge.
// master = serializer side, slave = environment side.
interface ecc_result_serializer_if #(
    parameter int COORD_W = 163,
    parameter int WORD_W  = 32
);
    logic               done;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [WORD_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic               dout_sel;
    logic               busy;
    logic               overrun;
    logic               clr_ovr;

    modport master (
        input  done, dx, dy, dout_ready, clr_ovr,
        output dout, dout_valid, dout_last, dout_sel, busy, overrun
    );

    modport slave (
        output done, dx, dy, dout_ready, clr_ovr,
        input  dout, dout_valid, dout_last, dout_sel, busy, overrun
    );
endinterface

// File: rtl/ecc_result_serializer.sv
// Captures an ECC result point on the rise of done and streams dx then dy
// as LSB-first narrow words over valid/ready, flagging dropped results.
module ecc_result_serializer #(
    parameter int COORD_W = 163,
    parameter int WORD_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ecc_result_serializer_if.master bus
);
    localparam int WPC   = (COORD_W + WORD_W - 1) / WORD_W;
    localparam int PAD_W = WPC * WORD_W;
    localparam int IDX_W = (2 * WPC > 1) ? $clog2(2 * WPC) : 1;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(2 * WPC - 1);
    localparam logic [IDX_W-1:0] WPC_I = IDX_W'(WPC);

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [IDX_W-1:0]   idx;
    logic               done_q;
    logic [WORD_W-1:0]  dout_r;
    logic               valid_r;
    logic               last_r;
    logic               sel_r;
    logic               busy_r;
    logic               ovr_r;

    logic               rise;
    logic [IDX_W-1:0]   idx_nxt;
    logic               xfer;
    logic               xfer_last;

    // Word i of the zero-padded {dy, dx} stream, dx words first.
    function automatic logic [WORD_W-1:0] word_of(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [IDX_W-1:0]   i
    );
        logic [2*PAD_W-1:0] cat;
        cat = '0;
        cat[COORD_W-1:0] = x;
        cat[PAD_W +: COORD_W] = y;
        return cat[i*WORD_W +: WORD_W];
    endfunction

    assign rise      = bus.done & ~done_q;
    assign idx_nxt   = idx + IDX_W'(1);
    assign xfer      = (state == SEND) & bus.dout_ready;
    assign xfer_last = xfer & (idx == LAST);

    // Capture/stream FSM with registered word, flags and overrun tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            idx     <= '0;
            done_q  <= 1'b1;
            dout_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            sel_r   <= 1'b0;
            busy_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            done_q <= bus.done;
            if (bus.clr_ovr) begin
                ovr_r <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        x_r     <= bus.dx;
                        y_r     <= bus.dy;
                        idx     <= '0;
                        dout_r  <= word_of(bus.dx, bus.dy, '0);
                        sel_r   <= 1'b0;
                        last_r  <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (xfer_last) begin
                        if (rise) begin
                            x_r    <= bus.dx;
                            y_r    <= bus.dy;
                            idx    <= '0;
                            dout_r <= word_of(bus.dx, bus.dy, '0);
                            sel_r  <= 1'b0;
                            last_r <= 1'b0;
                        end else begin
                            idx     <= '0;
                            dout_r  <= '0;
                            sel_r   <= 1'b0;
                            last_r  <= 1'b0;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx    <= idx_nxt;
                            dout_r <= word_of(x_r, y_r, idx_nxt);
                            sel_r  <= (idx_nxt >= WPC_I);
                            last_r <= (idx_nxt == LAST);
                        end
                        if (rise) begin
                            ovr_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = valid_r;
    assign bus.dout_last  = last_r;
    assign bus.dout_sel   = sel_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = ovr_r;
endmodule

// File: tb/tb_ecc_result_serializer.sv
// Scoreboard bench for ecc_result_serializer: stimulus pushes expected words,
// a negedge monitor pops them on every valid&ready transfer.
module tb_ecc_result_serializer;
    localparam int COORD_W = 163;
    localparam int WORD_W  = 32;

    localparam logic [162:0] DX_A  =
        163'h5_00000005_00000004_00000003_00000002_00000001;
    localparam logic [162:0] DY_1S = {163{1'b1}};
    localparam logic [162:0] DX_7  = 163'h7;
    localparam logic [162:0] DY_D  =
        163'h1_23456789_00000000_00000000_00000000_DEADBEEF;

    localparam logic [191:0] W_A  = {32'h5, 32'h5, 32'h4,
                                     32'h3, 32'h2, 32'h1};
    localparam logic [191:0] W_1S = {32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'hFFFFFFFF};
    localparam logic [191:0] W_7  = {32'h0, 32'h0, 32'h0,
                                     32'h0, 32'h0, 32'h7};
    localparam logic [191:0] W_D  = {32'h1, 32'h23456789, 32'h0,
                                     32'h0, 32'h0, 32'hDEADBEEF};

    logic clk = 1'b0;
    logic rst;

    ecc_result_serializer_if #(.COORD_W(COORD_W), .WORD_W(WORD_W)) bus ();

    ecc_result_serializer #(.COORD_W(COORD_W), .WORD_W(WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [33:0] sb[$];
    logic        hold_v = 1'b0;
    logic [33:0] hold_val;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic [191:0] xw, input logic [191:0] yw);
        for (int k = 0; k < 6; k++)
            sb.push_back({1'b0, 1'b0, xw[k*32 +: 32]});
        for (int k = 0; k < 6; k++)
            sb.push_back({1'b1, (k == 5), yw[k*32 +: 32]});
    endtask

    task automatic wait_drain(input string name);
        int cnt;
        cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            step();
            cnt++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: checks hold stability under backpressure and every transfer.
    always @(negedge clk) begin
        logic [33:0] cur;
        logic [33:0] exp;
        cur = {bus.dout_sel, bus.dout_last, bus.dout};
        if (!rst && bus.dout_valid) begin
            if (hold_v)
                chk("hold", 64'(cur), 64'(hold_val));
            if (bus.dout_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             cur);
                end else begin
                    exp = sb.pop_front();
                    chk("stream", 64'(cur), 64'(exp));
                end
                hold_v = 1'b0;
            end else begin
                hold_v   = 1'b1;
                hold_val = cur;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        logic [3:0] pat;
        int         cnt;
        pat = 4'b1001;
        rst = 1'b1;
        bus.done = 1'b0;
        bus.dx = '0;
        bus.dy = '0;
        bus.dout_ready = 1'b0;
        bus.clr_ovr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ovr", 64'(bus.overrun), 64'd0);
        chk("rst_dout", 64'(bus.dout), 64'd0);
        chk("rst_last", 64'(bus.dout_last), 64'd0);
        chk("rst_sel", 64'(bus.dout_sel), 64'd0);

        // basic stream, ready held high
        bus.dout_ready = 1'b1;
        bus.dx = DX_A;
        bus.dy = DY_1S;
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        @(negedge clk);
        chk("rise_cycle_valid", 64'(bus.dout_valid), 64'd0);
        step();
        bus.done = 1'b0;
        chk("lat_valid", 64'(bus.dout_valid), 64'd1);
        chk("lat_word0", 64'(bus.dout), 64'h1);
        chk("lat_busy", 64'(bus.busy), 64'd1);
        for (int i = 1; i < 12; i++) begin
            step();
            chk("no_bubble", 64'(bus.dout_valid), 64'd1);
        end
        step();
        chk("end_valid", 64'(bus.dout_valid), 64'd0);
        chk("end_busy", 64'(bus.busy), 64'd0);
        chk("basic_drain", 64'(sb.size()), 64'd0);

        // backpressure 1,0,0,1
        step();
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        step();
        bus.done = 1'b0;
        cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            bus.dout_ready = pat[cnt % 4];
            step();
            cnt++;
        end
        chk("bp_drain", 64'(sb.size()), 64'd0);
        bus.dout_ready = 1'b1;
        step();
        chk("bp_idle", 64'(bus.dout_valid), 64'd0);

        // overrun while stalled
        bus.dout_ready = 1'b0;
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        step();
        bus.done = 1'b0;
        step();
        step();
        bus.dx = '0;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.dx = DX_A;
        chk("ovr_set", 64'(bus.overrun), 64'd1);
        chk("ovr_word_kept", 64'(bus.dout), 64'h1);
        bus.dout_ready = 1'b1;
        wait_drain("ovr_drain");
        chk("ovr_sticky", 64'(bus.overrun), 64'd1);
        bus.clr_ovr = 1'b1;
        step();
        bus.clr_ovr = 1'b0;
        chk("ovr_clr", 64'(bus.overrun), 64'd0);

        // back-to-back on final transfer
        step();
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        step();
        bus.done = 1'b0;
        for (int i = 0; i < 11; i++)
            step();
        bus.dx = DX_7;
        bus.dy = DY_D;
        bus.done = 1'b1;
        push_res(W_7, W_D);
        step();
        bus.done = 1'b0;
        chk("b2b_ovr", 64'(bus.overrun), 64'd0);
        chk("b2b_valid", 64'(bus.dout_valid), 64'd1);
        chk("b2b_word", 64'(bus.dout), 64'h7);
        chk("b2b_sel", 64'(bus.dout_sel), 64'd0);
        wait_drain("b2b_drain");

        // reset mid-stream, with overrun set beforehand
        step();
        bus.dx = DX_A;
        bus.dy = DY_1S;
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        step();
        bus.done = 1'b0;
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        chk("mid_ovr", 64'(bus.overrun), 64'd1);
        rst = 1'b1;
        bus.dout_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.dout_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_ovr", 64'(bus.overrun), 64'd0);
        chk("mid_left", 64'(sb.size()), 64'd9);
        sb.delete();
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            step();
        chk("mid_quiet", 64'(bus.dout_valid), 64'd0);

        // reset with done held high
        bus.done = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("done_hi_quiet", 64'(bus.dout_valid), 64'd0);
        end
        bus.done = 1'b0;
        step();
        bus.done = 1'b1;
        push_res(W_A, W_1S);
        step();
        chk("done_hi_start", 64'(bus.dout_valid), 64'd1);
        wait_drain("done_hi_drain");
        step();
        chk("final_idle", 64'(bus.dout_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
